// File: rtl/lzc_pipe.sv
// lzc_pipe: two-stage leading-zero counter / normaliser on a valid/ready stream; define LZC_NORM_EN to build the out_norm shifter.
module lzc_pipe #(
  parameter int WIDTH = 11,
  parameter int SEG = 4,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             out_zero,
  output logic [WIDTH-1:0] out_norm
);
  localparam int NS = (WIDTH + SEG - 1) / SEG;
  localparam int PW = NS * SEG;
  localparam int PAD = PW - WIDTH;
  localparam int SW = $clog2(SEG + 1);

  function automatic logic [SW-1:0] seg_lzc(input logic [SEG-1:0] s);
    seg_lzc = SW'(SEG);
    for (int b = 0; b < SEG; b++) if (s[b]) seg_lzc = SW'(SEG - 1 - b);
  endfunction

  logic                   s2_adv, s1_adv, s1_load, s2_load;
  logic                   s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]       s1_data_q, s1_data_d;
  logic [NS-1:0]          s1_segz_q, s1_segz_d;
  logic [NS-1:0][SW-1:0]  s1_segc_q, s1_segc_d;
  logic [PW-1:0]          pad;
  logic                   out_valid_q, out_valid_d;
  logic [CW-1:0]          out_count_q, out_count_d, cnt;
  logic                   out_zero_q, out_zero_d;
`ifdef LZC_NORM_EN
  logic [WIDTH-1:0]       out_norm_q, out_norm_d;
`endif

  assign s2_adv    = !out_valid_q || out_ready;
  assign s1_adv    = !s1_valid_q || s2_adv;
  assign in_ready  = s1_adv;
  assign s1_load   = in_valid && s1_adv;
  assign s2_load   = s1_valid_q && s2_adv;
  assign out_valid = out_valid_q;
  assign out_count = out_count_q;
  assign out_zero  = out_zero_q;

  // Stage 1 next state: ones-padded segments yield per-segment zero flags and counts; the padding can only stop a count, never extend it
  always_comb begin
    pad = (PW'(in_data) << PAD) | ((PW'(1) << PAD) - PW'(1));
    s1_valid_d = s1_adv ? in_valid : s1_valid_q;
    s1_data_d = s1_load ? in_data : s1_data_q;
    for (int j = 0; j < NS; j++) begin
      s1_segz_d[j] = s1_load ? ~|pad[PW-1-j*SEG -: SEG] : s1_segz_q[j];
      s1_segc_d[j] = s1_load ? seg_lzc(pad[PW-1-j*SEG -: SEG]) : s1_segc_q[j];
    end
  end

  // Stage 2 next state: first non-zero segment sets the count; no such segment means WIDTH
  always_comb begin
    cnt = CW'(WIDTH);
    for (int j = NS - 1; j >= 0; j--) if (!s1_segz_q[j]) cnt = CW'(j * SEG) + CW'(s1_segc_q[j]);
    out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
    out_count_d = s2_load ? cnt : out_count_q;
    out_zero_d = s2_load ? ~|s1_data_q : out_zero_q;
`ifdef LZC_NORM_EN
    out_norm_d = s2_load ? s1_data_q << cnt : out_norm_q;
`endif
  end

  // Stage 1 registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q <= '0;
      s1_segz_q <= '0;
      s1_segc_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q <= s1_data_d;
      s1_segz_q <= s1_segz_d;
      s1_segc_q <= s1_segc_d;
    end
  end

  // Stage 2 (output) registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_zero_q <= 1'b0;
`ifdef LZC_NORM_EN
      out_norm_q <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
      out_zero_q <= out_zero_d;
`ifdef LZC_NORM_EN
      out_norm_q <= out_norm_d;
`endif
    end
  end

`ifdef LZC_NORM_EN
  assign out_norm = out_norm_q;
`else
  assign out_norm = '0;
`endif
endmodule
